// File: rtl/branch_ctrl.sv
// Branch controller: decodes control-flow opcodes and drives the program-counter
// load port. It owns a 4-entry return stack and a RUN/HALT state machine.
module branch_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] pc_addr_i,
  input  logic [7:0] instr_i,
  input  logic       zero_i,
  output logic       jmp_en_o,
  output logic [4:0] jmp_addr_o,
  output logic       halted_o,
  output logic       fault_o,
  output logic [2:0] depth_o
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpJmp  = 3'b001;
  localparam logic [2:0] OpJz   = 3'b010;
  localparam logic [2:0] OpJnz  = 3'b011;
  localparam logic [2:0] OpCall = 3'b100;
  localparam logic [2:0] OpRet  = 3'b101;
  localparam logic [2:0] OpHlt  = 3'b110;
  localparam logic [2:0] OpRsv  = 3'b111;

  localparam logic [2:0] StackDepth = 3'd4;

  logic [0:0] state_q, state_d;
  logic [2:0] sp_q, sp_d;
  logic [4:0] halt_addr_q, halt_addr_d;
  logic       fault_q, fault_d;
  logic [4:0] stack_q [4];

  logic       push;
  logic [4:0] push_val;
  logic [1:0] top_idx;
  logic [4:0] top_val;
  logic [2:0] opcode;
  logic [4:0] target;

  assign opcode   = instr_i[7:5];
  assign target   = instr_i[4:0];
  // 5-bit add wraps 31 -> 0 naturally.
  assign push_val = pc_addr_i + 5'd1;
  // Only meaningful while sp_q > 0; callers guard on that.
  assign top_idx  = sp_q[1:0] - 2'd1;
  assign top_val  = stack_q[top_idx];

  // Decode the current instruction into PC load request and next-state values.
  always_comb begin
    jmp_en_o    = 1'b0;
    jmp_addr_o  = 5'd0;
    state_d     = state_q;
    sp_d        = sp_q;
    halt_addr_d = halt_addr_q;
    fault_d     = fault_q;
    push        = 1'b0;
    if (rst_i) begin
      if (state_q == StHalt) begin
        // Park the PC on the halting instruction forever.
        jmp_en_o   = 1'b1;
        jmp_addr_o = halt_addr_q;
      end else begin
        case (opcode)
          OpNop, OpRsv: begin
            jmp_en_o   = 1'b0;
            jmp_addr_o = 5'd0;
          end
          OpJmp: begin
            jmp_en_o   = 1'b1;
            jmp_addr_o = target;
          end
          OpJz: begin
            jmp_en_o   = zero_i;
            jmp_addr_o = target;
          end
          OpJnz: begin
            jmp_en_o   = ~zero_i;
            jmp_addr_o = target;
          end
          OpCall: begin
            jmp_en_o = 1'b1;
            if (sp_q < StackDepth) begin
              jmp_addr_o = target;
              push       = 1'b1;
              sp_d       = sp_q + 3'd1;
            end else begin
              jmp_addr_o  = pc_addr_i;
              fault_d     = 1'b1;
              state_d     = StHalt;
              halt_addr_d = pc_addr_i;
            end
          end
          OpRet: begin
            jmp_en_o = 1'b1;
            if (sp_q != 3'd0) begin
              jmp_addr_o = top_val;
              sp_d       = sp_q - 3'd1;
            end else begin
              jmp_addr_o  = pc_addr_i;
              fault_d     = 1'b1;
              state_d     = StHalt;
              halt_addr_d = pc_addr_i;
            end
          end
          OpHlt: begin
            jmp_en_o    = 1'b1;
            jmp_addr_o  = pc_addr_i;
            state_d     = StHalt;
            halt_addr_d = pc_addr_i;
          end
          default: begin
            jmp_en_o   = 1'b0;
            jmp_addr_o = 5'd0;
          end
        endcase
      end
    end
  end

  // Register state, flags and return stack; synchronous reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StRun;
      sp_q        <= 3'd0;
      halt_addr_q <= 5'd0;
      fault_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stack_q[i] <= 5'd0;
      end
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      halt_addr_q <= halt_addr_d;
      fault_q     <= fault_d;
      if (push) begin
        stack_q[sp_q[1:0]] <= push_val;
      end
    end
  end

  assign halted_o = (state_q == StHalt);
  assign fault_o  = fault_q;
  assign depth_o  = sp_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios plus random traffic, compared
// against a queue-based behavioural model of the controller.
module tb_branch_ctrl;

  logic       clk_i;
  logic       rst_i;
  logic [4:0] pc_addr_i;
  logic [7:0] instr_i;
  logic       zero_i;
  logic       jmp_en_o;
  logic [4:0] jmp_addr_o;
  logic       halted_o;
  logic       fault_o;
  logic [2:0] depth_o;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_stack[$];
  bit m_halted;
  bit m_fault;
  int m_halt_addr;

  branch_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pc_addr_i  (pc_addr_i),
    .instr_i    (instr_i),
    .zero_i     (zero_i),
    .jmp_en_o   (jmp_en_o),
    .jmp_addr_o (jmp_addr_o),
    .halted_o   (halted_o),
    .fault_o    (fault_o),
    .depth_o    (depth_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Model: what the controller should request in the current cycle.
  task automatic model_outputs(input bit rst, input int pc, input int instr, input bit zero,
                               output int en, output int addr);
    int op;
    int tgt;
    op   = instr / 32;
    tgt  = instr % 32;
    en   = 0;
    addr = 0;
    if (!rst) return;
    if (m_halted) begin
      en   = 1;
      addr = m_halt_addr;
      return;
    end
    case (op)
      1: begin en = 1; addr = tgt; end
      2: begin en = zero ? 1 : 0; addr = tgt; end
      3: begin en = zero ? 0 : 1; addr = tgt; end
      4: begin en = 1; addr = (m_stack.size() < 4) ? tgt : pc; end
      5: begin en = 1; addr = (m_stack.size() > 0) ? m_stack[$] : pc; end
      6: begin en = 1; addr = pc; end
      default: begin en = 0; addr = 0; end
    endcase
  endtask

  // Model: effect of the rising edge.
  task automatic model_edge(input bit rst, input int pc, input int instr);
    int op;
    op = instr / 32;
    if (!rst) begin
      m_stack.delete();
      m_halted    = 0;
      m_fault     = 0;
      m_halt_addr = 0;
      return;
    end
    if (m_halted) return;
    case (op)
      4: begin
        if (m_stack.size() < 4) m_stack.push_back((pc + 1) % 32);
        else begin m_fault = 1; m_halted = 1; m_halt_addr = pc; end
      end
      5: begin
        if (m_stack.size() > 0) void'(m_stack.pop_back());
        else begin m_fault = 1; m_halted = 1; m_halt_addr = pc; end
      end
      6: begin m_halted = 1; m_halt_addr = pc; end
      default: ;
    endcase
  endtask

  // One cycle: drive inputs after the falling edge, check combinational
  // outputs, then check registered outputs just after the rising edge.
  task automatic step(input bit rst, input int pc, input int instr, input bit zero);
    int e_en;
    int e_addr;
    @(negedge clk_i);
    rst_i     = rst;
    pc_addr_i = 5'(pc);
    instr_i   = 8'(instr);
    zero_i    = zero;
    #1;
    model_outputs(rst, pc, instr, zero, e_en, e_addr);
    chk("jmp_en", int'(jmp_en_o), e_en);
    chk("jmp_addr", int'(jmp_addr_o), e_addr);
    @(posedge clk_i);
    model_edge(rst, pc, instr);
    #1;
    chk("depth", int'(depth_o), m_stack.size());
    chk("halted", int'(halted_o), int'(m_halted));
    chk("fault", int'(fault_o), int'(m_fault));
  endtask

  initial begin
    int op;
    rst_i     = 1'b0;
    pc_addr_i = 5'd0;
    instr_i   = 8'h00;
    zero_i    = 1'b0;
    m_halted    = 0;
    m_fault     = 0;
    m_halt_addr = 0;

    // Reset holds outputs low even on a JMP.
    step(0, 0, 8'h39, 0);
    step(0, 0, 8'h39, 0);

    // Conditional jumps.
    step(1, 3, 8'h4A, 1);
    step(1, 3, 8'h4A, 0);
    step(1, 3, 8'h6A, 0);
    step(1, 3, 8'h6A, 1);
    step(1, 4, 8'h39, 0);
    step(1, 4, 8'hE5, 1);

    // CALL then RET returns to pc+1.
    step(1, 5, 8'h94, 0);
    step(1, 20, 8'hA0, 0);
    chk("ret_addr_literal", m_stack.size(), 0);

    // Wrap at pc=31, fill the stack, then overflow.
    step(1, 31, 8'h80, 0);
    step(1, 1, 8'h82, 0);
    step(1, 2, 8'h83, 0);
    step(1, 3, 8'h84, 0);
    step(1, 9, 8'h81, 0);
    step(1, 0, 8'h39, 1);
    step(1, 0, 8'hA0, 0);

    // Underflow.
    step(0, 0, 8'h00, 0);
    step(1, 7, 8'hA0, 0);
    step(1, 8, 8'h00, 0);
    step(1, 9, 8'h94, 1);

    // HLT leaves fault clear.
    step(0, 0, 8'h00, 0);
    step(1, 12, 8'hC0, 0);
    step(1, 13, 8'h39, 0);
    step(1, 14, 8'hA0, 0);

    // Reset from HALT with depth 3.
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'h85, 0);
    step(1, 5, 8'h86, 0);
    step(1, 6, 8'h87, 0);
    step(1, 7, 8'hC0, 0);
    step(0, 7, 8'hA0, 0);
    step(1, 8, 8'h00, 0);

    // Pop back through the wrapped entry.
    step(1, 31, 8'h90, 0);
    step(1, 16, 8'hA0, 0);

    // Random traffic, CALL/RET-heavy with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bit r;
      int ins;
      r   = ($urandom_range(0, 19) != 0);
      op  = $urandom_range(0, 9);
      if (op > 7) op = (op == 8) ? 4 : 5;
      if (op == 6 && $urandom_range(0, 3) != 0) op = 0;
      ins = op * 32 + $urandom_range(0, 31);
      step(r, $urandom_range(0, 31), ins, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset: one clock, synchronous, active-low; sampled on rising edge of clk_i.
REQ-003 SHALL have port pc_addr_i, input, 5, current PC value (program counter addr_o).
REQ-004 SHALL have port instr_i, input, 8, instruction at pc_addr_i; [7:5] opcode, [4:0] target address.
REQ-005 SHALL have port zero_i, input, 1, accumulator zero flag, valid in the same cycle as instr_i.
REQ-006 SHALL have port jmp_en_o, output, 1, load request to program counter jmp_en_i.
REQ-007 SHALL have port jmp_addr_o, output, 5, load value to program counter jmp_addr_i.
REQ-008 SHALL have port halted_o, output, 1, core halted (sticky until reset).
REQ-009 SHALL have port fault_o, output, 1, stack overflow/underflow occurred (sticky until reset).
REQ-010 SHALL have port depth_o, output, 3, return-stack occupancy, 0..4.

Function
REQ-011 SHALL decode opcodes: 000 NOP, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 HLT, 111 NOP (reserved).
REQ-012 SHALL implement two states, RUN and HALT; reset enters RUN.
REQ-013 SHALL, in RUN, drive jmp_en_o/jmp_addr_o combinationally from instr_i, zero_i and stack top, so the PC loads the target on the next rising edge (zero added latency).
REQ-014 SHALL, in RUN, treat NOP/111 as: jmp_en_o=0, jmp_addr_o=0, no state change (PC self-increments).
REQ-015 SHALL, for JMP: jmp_en_o=1, jmp_addr_o=instr_i[4:0].
REQ-016 SHALL, for JZ: jmp_en_o=zero_i; for JNZ: jmp_en_o=~zero_i; jmp_addr_o=instr_i[4:0] in both; not-taken drives jmp_en_o=0.
REQ-017 SHALL, for CALL with depth<4: jmp_en_o=1, jmp_addr_o=instr_i[4:0]; push (pc_addr_i+1) mod 32 at the edge (31 -> 0 wrap); depth +1.
REQ-018 SHALL, for RET with depth>0: jmp_en_o=1, jmp_addr_o=top entry; pop at the edge; depth -1.
REQ-019 SHALL implement the return stack as 4 x 5-bit LIFO; only top entry readable; no other access path.
REQ-020 SHALL, for CALL with depth=4 (overflow): no push, jmp_en_o=1, jmp_addr_o=pc_addr_i, set fault_o, enter HALT at the edge.
REQ-021 SHALL, for RET with depth=0 (underflow): no pop, jmp_en_o=1, jmp_addr_o=pc_addr_i, set fault_o, enter HALT.
REQ-022 SHALL, for HLT: jmp_en_o=1, jmp_addr_o=pc_addr_i, latch pc_addr_i into halt address register, enter HALT; fault_o unchanged.
REQ-023 SHALL latch halt address = pc_addr_i on every RUN->HALT transition (HLT, overflow, underflow).
REQ-024 SHALL, in HALT: jmp_en_o=1, jmp_addr_o=halt address every cycle, ignore instr_i/zero_i, stack frozen, halted_o=1.
REQ-025 SHALL drive halted_o and fault_o from registers (asserted from the cycle after the causing edge onward).
REQ-026 SHALL drive depth_o from the registered stack pointer.

Reset
REQ-027 SHALL, while rst_i=0 at a rising edge: state=RUN, depth=0, halted_o=0, fault_o=0, halt address=0, stack entries=0.
REQ-028 SHALL force jmp_en_o=0 and jmp_addr_o=0 combinationally while rst_i=0, regardless of instr_i.
REQ-029 SHALL allow reset in any state (including mid-CALL/RET and HALT) with reset taking priority over every instruction in that cycle.
REQ-030 SHALL resume decoding in RUN on the first edge after rst_i returns to 1.

Verification
REQ-031 SHALL cover reset: rst_i=0 one edge, instr_i=8'h39 (JMP 25) -> jmp_en_o=0, jmp_addr_o=0, depth_o=0, halted_o=0, fault_o=0.
REQ-032 SHALL cover conditional jumps: pc=3, instr=8'h4A (JZ 10), zero_i=1 -> jmp_en_o=1, jmp_addr_o=10; zero_i=0 -> jmp_en_o=0; JNZ 10 (8'h6A) with zero_i=0 -> jmp_en_o=1.
REQ-033 SHALL cover CALL/RET: pc=5, instr=8'h94 (CALL 20) -> jmp_addr_o=20, depth_o=1; then pc=20, instr=8'hA0 (RET) -> jmp_en_o=1, jmp_addr_o=6, depth_o=0 after the edge.
REQ-034 SHALL cover wrap and overflow: CALL at pc=31 pushes 0; four CALLs -> depth_o=4; fifth CALL at pc=9 -> jmp_addr_o=9, fault_o=1, halted_o=1, depth_o stays 4.
REQ-035 SHALL cover underflow and HLT: RET at depth 0, pc=7 -> fault_o=1, halted_o=1, jmp_addr_o=7 every later cycle; separately HLT (8'hC0) at pc=12 -> halted_o=1, fault_o=0, jmp_addr_o=12 held.
REQ-036 SHALL cover reset mid-operation: from HALT with depth 3, rst_i=0 one edge -> halted_o=0, fault_o=0, depth_o=0; next NOP -> jmp_en_o=0.
